// File: rtl/param_seq_alu.sv
// Multi-cycle ALU with a generic operand width and a double-width result.
// It provides iterative signed/unsigned multiply and divide, plus single-cycle AND, OR, XOR and ADD.
module param_seq_alu #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 valid,
    input  logic [2:0]           mode,
    input  logic [WIDTH-1:0]     in_A,
    input  logic [WIDTH-1:0]     in_B,
    output logic [2*WIDTH-1:0]   out,
    output logic                 ready,
    output logic                 busy,
    output logic                 div_zero
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Two's complement magnitude when the operand is treated as signed.
    function automatic logic [WIDTH-1:0] mag_w(input logic [WIDTH-1:0] x, input logic sgn);
        return (sgn && x[WIDTH-1]) ? (~x + WIDTH'(1)) : x;
    endfunction

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x, input logic en);
        return en ? (~x + WIDTH'(1)) : x;
    endfunction

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 is_div_q, is_div_d;
    logic                 neg_q, neg_d;
    logic                 rneg_q, rneg_d;
    logic                 dz_q, dz_d;
    logic [WIDTH-1:0]     orig_a_q, orig_a_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic [2*WIDTH-1:0]   a_sh_q, a_sh_d;
    logic [2*WIDTH-1:0]   work_q, work_d;
    logic [2*WIDTH-1:0]   out_q, out_d;

    logic                 accept_s;
    logic                 sgn_s;
    logic [WIDTH:0]       trial_s;
    logic [WIDTH:0]       diff_s;
    logic                 qbit_s;
    logic [2*WIDTH-1:0]   step_s;
    logic [WIDTH:0]       sum_s;

    // Next-state, datapath step and result formatting.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        dz_d     = dz_q;
        orig_a_d = orig_a_q;
        b_d      = b_q;
        a_sh_d   = a_sh_q;
        work_d   = work_q;
        out_d    = out_q;
        accept_s = valid && ((state_q == ST_IDLE) || (state_q == ST_DONE));
        sgn_s    = mode[2];
        sum_s    = {1'b0, in_A} + {1'b0, in_B};
        // Divide trial: shift the next dividend bit into the partial remainder.
        trial_s  = work_q[2*WIDTH-1:WIDTH-1];
        diff_s   = trial_s - {1'b0, b_q};
        qbit_s   = ~diff_s[WIDTH];
        step_s   = work_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept_s) begin
                    cnt_d    = '0;
                    orig_a_d = in_A;
                    is_div_d = mode[0];
                    if (!mode[1]) begin
                        neg_d   = sgn_s & (in_A[WIDTH-1] ^ in_B[WIDTH-1]);
                        rneg_d  = sgn_s & in_A[WIDTH-1];
                        dz_d    = mode[0] && (in_B == '0);
                        b_d     = mag_w(in_B, sgn_s);
                        a_sh_d  = {{WIDTH{1'b0}}, mag_w(in_A, sgn_s)};
                        work_d  = mode[0] ? {{WIDTH{1'b0}}, mag_w(in_A, sgn_s)} : '0;
                        state_d = ST_CALC;
                    end else begin
                        dz_d    = 1'b0;
                        state_d = ST_DONE;
                        case (mode)
                            3'd2:    out_d = {{WIDTH{1'b0}}, in_A & in_B};
                            3'd3:    out_d = {{WIDTH{1'b0}}, in_A | in_B};
                            3'd6:    out_d = {{WIDTH{1'b0}}, in_A ^ in_B};
                            3'd7:    out_d = {{(WIDTH-1){1'b0}}, sum_s};
                            default: out_d = out_q;
                        endcase
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (is_div_q) begin
                    step_s = {qbit_s ? diff_s[WIDTH-1:0] : trial_s[WIDTH-1:0],
                              work_q[WIDTH-2:0], qbit_s};
                end else begin
                    step_s = work_q + (b_q[0] ? a_sh_q : '0);
                    a_sh_d = a_sh_q << 1;
                    b_d    = b_q >> 1;
                end
                work_d = step_s;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                    if (!is_div_q) begin
                        out_d = neg_q ? (~step_s + (2*WIDTH)'(1)) : step_s;
                    end else if (dz_q) begin
                        out_d = {orig_a_q, {WIDTH{1'b1}}};
                    end else begin
                        out_d = {neg_w(step_s[2*WIDTH-1:WIDTH], rneg_q),
                                 neg_w(step_s[WIDTH-1:0], neg_q)};
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            dz_q     <= 1'b0;
            orig_a_q <= '0;
            b_q      <= '0;
            a_sh_q   <= '0;
            work_q   <= '0;
            out_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            dz_q     <= dz_d;
            orig_a_q <= orig_a_d;
            b_q      <= b_d;
            a_sh_q   <= a_sh_d;
            work_q   <= work_d;
            out_q    <= out_d;
        end
    end

    assign out      = out_q;
    assign ready    = (state_q == ST_DONE);
    assign busy     = (state_q == ST_CALC);
    assign div_zero = (state_q == ST_DONE) && dz_q;

endmodule

// File: tb/tb_param_seq_alu.sv
// Randomised and directed bench for param_seq_alu at WIDTH=32 and WIDTH=8,
// checked against an arithmetic reference model.
module tb_param_seq_alu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid;
    logic        sel;
    logic [2:0]  mode;
    logic [31:0] in_a, in_b;

    logic [63:0] out32;
    logic        ready32, busy32, dz32;
    logic [15:0] out8;
    logic        ready8, busy8, dz8;
    logic        valid32, valid8;

    logic [63:0] out_s;
    logic        rdy_s, busy_s, dz_s;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    assign valid32 = valid & ~sel;
    assign valid8  = valid & sel;
    assign out_s   = sel ? {48'd0, out8} : out32;
    assign rdy_s   = sel ? ready8 : ready32;
    assign busy_s  = sel ? busy8 : busy32;
    assign dz_s    = sel ? dz8 : dz32;

    param_seq_alu #(.WIDTH(32)) u_alu32 (
        .clk(clk), .rst_n(rst_n), .valid(valid32), .mode(mode),
        .in_A(in_a), .in_B(in_b), .out(out32), .ready(ready32),
        .busy(busy32), .div_zero(dz32)
    );

    param_seq_alu #(.WIDTH(8)) u_alu8 (
        .clk(clk), .rst_n(rst_n), .valid(valid8), .mode(mode),
        .in_A(in_a[7:0]), .in_B(in_b[7:0]), .out(out8), .ready(ready8),
        .busy(busy8), .div_zero(dz8)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Returns {div_zero, result} for a w-bit operation.
    function automatic logic [64:0] model(input int w, input logic [2:0] m,
                                          input logic [31:0] a, input logic [31:0] b);
        logic [63:0] mw, m2, ua, ub, r;
        longint      sa, sb, q, rm;
        logic        dz;
        mw = (64'd1 << w) - 64'd1;
        m2 = (mw << w) | mw;
        ua = {32'd0, a} & mw;
        ub = {32'd0, b} & mw;
        sa = ua[w-1] ? longint'(ua) - (longint'(1) << w) : longint'(ua);
        sb = ub[w-1] ? longint'(ub) - (longint'(1) << w) : longint'(ub);
        dz = 1'b0;
        r  = 64'd0;
        case (m)
            3'd0: r = ua * ub;
            3'd4: r = sa * sb;
            3'd1, 3'd5: begin
                if (ub == 64'd0) begin
                    dz = 1'b1;
                    r  = (ua << w) | mw;
                end else begin
                    if (m == 3'd1) begin
                        q  = longint'(ua / ub);
                        rm = longint'(ua % ub);
                    end else begin
                        q  = sa / sb;
                        rm = sa % sb;
                    end
                    r = ((64'(rm) & mw) << w) | (64'(q) & mw);
                end
            end
            3'd2: r = ua & ub;
            3'd3: r = ua | ub;
            3'd6: r = ua ^ ub;
            default: r = ua + ub;
        endcase
        return {dz, r & m2};
    endfunction

    function automatic logic [31:0] pick(input int w);
        logic [31:0] mw;
        mw = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_00FF;
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return mw;
            3:       return 32'd1 << (w - 1);
            default: return $urandom & mw;
        endcase
    endfunction

    task automatic run_op(input bit s, input logic [2:0] m, input logic [31:0] a,
                          input logic [31:0] b, input bit poke);
        logic [64:0] e;
        int          w, lat, bcnt;
        bit          iter;
        w    = s ? 8 : 32;
        e    = model(w, m, a, b);
        iter = !m[1];
        @(negedge clk);
        sel   = s;
        mode  = m;
        in_a  = a;
        in_b  = b;
        valid = 1'b1;
        @(posedge clk);
        #1;
        valid = 1'b0;
        mode  = 3'($urandom);
        in_a  = $urandom;
        in_b  = $urandom;
        lat   = 0;
        bcnt  = 0;
        while (!rdy_s && lat < 100) begin
            if (busy_s) bcnt++;
            if (poke) valid = (lat == 3);
            @(posedge clk);
            #1;
            lat++;
        end
        valid = 1'b0;
        check_val("latency", 64'(lat), iter ? 64'(w) : 64'd0);
        check_val("busy_cycles", 64'(bcnt), iter ? 64'(w) : 64'd0);
        check_val("busy_at_ready", {63'd0, busy_s}, 64'd0);
        check_val("result", out_s, e[63:0]);
        check_val("div_zero", {63'd0, dz_s}, {63'd0, e[64]});
        @(posedge clk);
        #1;
        check_val("ready_pulse", {63'd0, rdy_s}, 64'd0);
        check_val("out_hold", out_s, e[63:0]);
    endtask

    initial begin
        int lat, rcnt;
        rst_n = 1'b0;
        valid = 1'b0;
        sel   = 1'b0;
        mode  = 3'd0;
        in_a  = 32'd0;
        in_b  = 32'd0;
        #12;
        check_val("rst_out", out32, 64'd0);
        check_val("rst_flags", {61'd0, ready32, busy32, dz32}, 64'd0);
        check_val("rst_out8", {48'd0, out8}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(1'b0, 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op(1'b0, 3'd4, 32'hFFFF_FFFD, 32'd7, 1'b0);
        run_op(1'b0, 3'd5, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op(1'b0, 3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op(1'b0, 3'd1, 32'h0000_1234, 32'd0, 1'b0);
        run_op(1'b0, 3'd5, 32'hFFFF_FFF0, 32'd0, 1'b0);
        run_op(1'b0, 3'd7, 32'hFFFF_FFFF, 32'd1, 1'b0);
        run_op(1'b0, 3'd6, 32'hF0F0_F0F0, 32'hFFFF_0000, 1'b0);
        run_op(1'b0, 3'd0, 32'd1234, 32'd777, 1'b1);
        run_op(1'b1, 3'd0, 32'hFF, 32'hFF, 1'b0);
        run_op(1'b1, 3'd1, 32'hFF, 32'h10, 1'b0);
        run_op(1'b1, 3'd5, 32'h80, 32'hFF, 1'b0);
        run_op(1'b1, 3'd1, 32'h37, 32'h5, 1'b1);

        // Back-to-back: AND accepted in the DONE cycle of a MULU.
        @(negedge clk);
        sel = 1'b0; mode = 3'd0; in_a = 32'd3; in_b = 32'd5; valid = 1'b1;
        @(posedge clk);
        #1;
        valid = 1'b0;
        lat = 0;
        while (!ready32 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_val("b2b_mul", out32, 64'd15);
        mode = 3'd2; in_a = 32'hFF; in_b = 32'h0F; valid = 1'b1;
        @(posedge clk);
        #1;
        valid = 1'b0;
        check_val("b2b_ready2", {63'd0, ready32}, 64'd1);
        check_val("b2b_and", out32, 64'h0F);
        @(posedge clk);
        #1;
        check_val("b2b_drop", {63'd0, ready32}, 64'd0);

        // Reset during CALC iteration 10.
        @(negedge clk);
        sel = 1'b0; mode = 3'd1; in_a = 32'hDEAD_BEEF; in_b = 32'd3; valid = 1'b1;
        @(posedge clk);
        #1;
        valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_val("abort_out", out32, 64'd0);
        check_val("abort_flags", {61'd0, ready32, busy32, dz32}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        rcnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (ready32) rcnt++;
        end
        check_val("abort_no_ready", 64'(rcnt), 64'd0);
        run_op(1'b0, 3'd1, 32'd100, 32'd7, 1'b0);

        for (int i = 0; i < 40; i++) begin
            bit s;
            s = 1'($urandom_range(0, 1));
            run_op(s, 3'($urandom), pick(s ? 8 : 32), pick(s ? 8 : 32), 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
